// File: rtl/bk_adder_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
package bk_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Round-robin successor of requester g.
  function automatic int unsigned next_ptr(input int unsigned g, input int unsigned nreq);
    return (g + 1) % nreq;
  endfunction

endpackage

// File: rtl/bk_adder_arbiter_if.sv
// Requester, adder and response signals of the adder arbiter.
interface bk_adder_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 6,
  parameter int IDW   = 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_last;

  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH:0]        add_res;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_last;
  logic                  busy;

  // Handshake: a transfer happens on a cycle where valid && ready. req_ready is
  // combinational from req_valid, so a requester must not gate valid on ready;
  // rsp_valid stays up with stable payload until rsp_ready is seen.
  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_last, add_res, rsp_ready,
    output req_ready, add_a, add_b, add_cin,
           rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_last, add_res, rsp_ready,
    input  req_ready, add_a, add_b, add_cin,
           rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, busy
  );
endinterface

// File: rtl/bk_adder_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester at or above ptr, with wrap.
module bk_adder_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!any && valid[idx]) begin
        any        = 1'b1;
        id         = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bk_adder_arbiter.sv
// Shares one external carry-in adder between NREQ requesters; bursts chain the
// carry across limbs and hold the grant until the limb marked last.
module bk_adder_arbiter
  import bk_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 6,
  parameter int IDW   = 1
) (
  input logic               clk,
  input logic               rst_n,
  bk_adder_arbiter_if.slave bus
);

  arb_state_t      state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  lock_id;
  logic            carry_q;

  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic            rsp_cout_q;
  logic            rsp_last_q;

  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;

  logic            has_grant;
  logic [IDW-1:0]  grant_id;
  logic            can_issue;
  logic [NREQ-1:0] ready;
  logic            accept;
  logic            last_g;

  bk_adder_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  assign can_issue = !rsp_valid_q || bus.rsp_ready;

  // Grant is forced off while reset is held so the adder and ready lines go quiet at once.
  always_comb begin
    has_grant = 1'b0;
    grant_id  = '0;
    ready     = '0;
    if (rst_n) begin
      if (state == LOCKED) begin
        has_grant = 1'b1;
        grant_id  = lock_id;
        if (bus.req_valid[lock_id] && can_issue) ready[lock_id] = 1'b1;
      end else begin
        has_grant = pick_any;
        grant_id  = pick_id;
        ready     = pick_grant & {NREQ{can_issue}};
      end
    end
  end

  assign accept = |ready;
  assign last_g = bus.req_last[grant_id];

  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (has_grant) begin
      bus.add_a   = bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
      bus.add_b   = bus.req_b[int'(grant_id)*WIDTH +: WIDTH];
      bus.add_cin = (state == LOCKED) ? carry_q : bus.req_cin[grant_id];
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = last_g ? IDLE : LOCKED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_id     <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= grant_id;
        rsp_sum_q   <= bus.add_res[WIDTH-1:0];
        rsp_cout_q  <= bus.add_res[WIDTH];
        rsp_last_q  <= last_g;
        carry_q     <= bus.add_res[WIDTH];
        // The pointer only moves when a burst closes.
        if (last_g) rr_ptr <= IDW'(next_ptr(int'(grant_id), NREQ));
        else        lock_id <= grant_id;
      end else if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.busy      = (state == LOCKED);

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Bench for bk_adder_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_bk_adder_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 6;
  localparam int IDW  = 1;
  localparam int EW   = IDW + 2 + W;

  logic clk;
  logic rst_n;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_last;
  logic              rsp_ready;

  int n_checks;
  int n_fail;

  // Reference model state
  int      m_owner;
  int      m_ptr;
  bit      m_rv;
  bit      m_carry;
  logic [EW-1:0] exp_q[$];

  bk_adder_arbiter_if #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) bus ();

  bk_adder_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.req_valid = req_valid;
  assign bus.req_a     = req_a;
  assign bus.req_b     = req_b;
  assign bus.req_cin   = req_cin;
  assign bus.req_last  = req_last;
  assign bus.rsp_ready = rsp_ready;
  // Stand-in for the external adder.
  assign bus.add_res   = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_rv    = 1'b0;
    m_carry = 1'b0;
    exp_q.delete();
  endtask

  // Decide who the rules say wins this cycle, then log the transaction the edge will produce.
  task automatic model_eval();
    int w;
    bit can;
    int cin_eff;
    int total;
    int av;
    int bv;
    logic [NREQ-1:0] exp_ready;
    can = !m_rv || rsp_ready;
    w = -1;
    if (m_owner >= 0) begin
      if (req_valid[m_owner]) w = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    end
    if (!can) w = -1;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    if (m_rv && rsp_ready) begin
      void'(exp_q.pop_front());
      m_rv = 1'b0;
    end
    if (w >= 0) begin
      av = int'(req_a[w*W +: W]);
      bv = int'(req_b[w*W +: W]);
      cin_eff = (m_owner >= 0) ? int'(m_carry) : int'(req_cin[w]);
      total = av + bv + cin_eff;
      check("add_a", 32'(bus.add_a), 32'(av));
      check("add_b", 32'(bus.add_b), 32'(bv));
      check("add_cin", 32'(bus.add_cin), 32'(cin_eff));
      exp_q.push_back({IDW'(w), req_last[w], total >= (1 << W), W'(total)});
      m_rv    = 1'b1;
      m_carry = (total >= (1 << W));
      if (req_last[w]) begin
        m_owner = -1;
        m_ptr   = (w + 1) % NREQ;
      end else begin
        m_owner = w;
      end
    end
  endtask

  task automatic post_check();
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
    check("busy", 32'(bus.busy), 32'(m_owner >= 0));
    if (m_rv && exp_q.size() > 0)
      check("rsp_payload", 32'({bus.rsp_id, bus.rsp_last, bus.rsp_cout, bus.rsp_sum}), 32'(exp_q[0]));
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
    post_check();
  endtask

  task automatic set_limb(input int r, input int a, input int b, input bit cin, input bit last);
    req_a[r*W +: W] = W'(a);
    req_b[r*W +: W] = W'(b);
    req_cin[r]      = cin;
    req_last[r]     = last;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_last  = '0;
    rsp_ready = 1'b1;
    model_reset();

    #2;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_add_a", 32'(bus.add_a), 32'd0);
    check("reset_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single limb with carry out
    set_limb(0, 63, 1, 1'b0, 1'b1);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    check("single_sum", 32'(bus.rsp_sum), 32'd0);
    check("single_cout", 32'(bus.rsp_cout), 32'd1);
    check("single_id", 32'(bus.rsp_id), 32'd0);
    check("single_last", 32'(bus.rsp_last), 32'd1);
    check("single_busy", 32'(bus.busy), 32'd0);
    step();

    // Two-limb chained burst on requester 1
    set_limb(1, 63, 1, 1'b0, 1'b0);
    req_valid = 2'b10;
    step();
    check("chain1_sum", 32'(bus.rsp_sum), 32'd0);
    check("chain1_cout", 32'(bus.rsp_cout), 32'd1);
    check("chain_busy_mid", 32'(bus.busy), 32'd1);
    set_limb(1, 5, 2, 1'b0, 1'b1);
    step();
    req_valid = '0;
    check("chain2_sum", 32'(bus.rsp_sum), 32'd8);
    check("chain2_cout", 32'(bus.rsp_cout), 32'd0);
    check("chain_busy_end", 32'(bus.busy), 32'd0);
    step();

    // Fairness: both requesting single-limb bursts
    set_limb(0, 1, 2, 1'b0, 1'b1);
    set_limb(1, 3, 4, 1'b0, 1'b1);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fair_id", 32'(bus.rsp_id), 32'(i % 2));
    end

    // Lock exclusion
    set_limb(0, 10, 20, 1'b1, 1'b0);
    set_limb(1, 7, 7, 1'b0, 1'b1);
    req_valid = 2'b11;
    step();
    check("lock_open_id", 32'(bus.rsp_id), 32'd0);
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lock_excl_ready1", 32'(bus.req_ready[1]), 32'd0);
    end
    set_limb(0, 1, 1, 1'b0, 1'b1);
    req_valid = 2'b11;
    step();
    check("lock_close_id", 32'(bus.rsp_id), 32'd0);
    req_valid = 2'b10;
    step();
    check("lock_next_id", 32'(bus.rsp_id), 32'd1);
    req_valid = '0;

    // Backpressure then simultaneous accept and drain
    rsp_ready = 1'b0;
    set_limb(0, 9, 9, 1'b0, 1'b1);
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_held_id", 32'(bus.rsp_id), 32'd1);
      check("bp_held_sum", 32'(bus.rsp_sum), 32'd14);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    check("bp_no_bubble", 32'(bus.rsp_valid), 32'd1);
    check("bp_new_sum", 32'(bus.rsp_sum), 32'd18);
    step();

    // Async reset in the middle of a burst
    set_limb(0, 4, 4, 1'b0, 1'b0);
    req_valid = 2'b01;
    step();
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("areset_busy", 32'(bus.busy), 32'd0);
    check("areset_req_ready", 32'(bus.req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_limb(1, 0, 0, 1'b1, 1'b1);
    req_valid = 2'b10;
    step();
    req_valid = '0;
    check("post_reset_sum", 32'(bus.rsp_sum), 32'd1);
    check("post_reset_id", 32'(bus.rsp_id), 32'd1);
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NREQ; r++)
        set_limb(r, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
